// File: rtl/uart_pkg.sv
// Shared types and helpers for the single-clock UART transmitter:
// FSM state encoding, parity-mode constants and the baud divider computation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Rounded clock cycles per line bit.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock TX FIFO. Full/empty are derived from the registered count, so a push
// seen while full is dropped even if a pop happens in the same cycle.
module uart_tx_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// Single-clock UART transmitter with baud generator and TX FIFO.
// Define UART_TX_PARITY_EN to build the optional parity bit (mode chosen by PARITY).
module uart_tx_fifo_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           tdata,
  input  logic                        twrreq,
  output logic                        tfull,
  output logic [$clog2(FIFO_DEPTH):0] tcount,
  output logic                        overflow,
  output logic                        busy,
  output logic                        uart_txd
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DCW = $clog2(DIV);
  localparam int BCW = $clog2(DATA_W);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  tx_state_e         state_q, state_d;
  logic [DCW-1:0]    baud_cnt_q;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              baud_tick;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              fifo_empty;

  uart_tx_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (twrreq),
    .push_data (tdata),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (tcount),
    .full      (tfull),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign baud_tick = (baud_cnt_q == DIV_LAST);
  assign busy      = (state_q != ST_IDLE);

  // The counter sits at zero in IDLE and wraps on every tick, so it is already
  // zero whenever START is entered, including the gapless STOP->START path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= (state_q == ST_IDLE || baud_tick) ? '0 : baud_cnt_q + 1'b1;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else if (pop) par_q <= (PARITY == PAR_ODD) ? ~^pop_data : ^pop_data;
  end
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    uart_txd  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = pop_data;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        uart_txd = 1'b0;
        if (baud_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        uart_txd = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PAR: begin
        uart_txd = par_q;
        if (baud_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = pop_data;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
